// File: rtl/data_plane_arbiter_if.sv
// Handshake bundle between the data-plane arbiter and the per-node
// transmitters / control plane. The arbiter uses the master view.
interface data_plane_arbiter_if #(
    parameter int NODES = 4,
    parameter int IDW   = $clog2(NODES)
);
    logic [NODES-1:0] req;
    logic [NODES-1:0] complete;
    logic [NODES-1:0] data_tx_flag;
    logic [IDW-1:0]   grant_id;
    logic             busy;
    logic             timeout_err;
    logic [15:0]      grant_count;

    modport master (
        input  req,
        input  complete,
        output data_tx_flag,
        output grant_id,
        output busy,
        output timeout_err,
        output grant_count
    );

    modport slave (
        output req,
        output complete,
        input  data_tx_flag,
        input  grant_id,
        input  busy,
        input  timeout_err,
        input  grant_count
    );
endinterface

// File: rtl/data_plane_arbiter.sv
// Round-robin arbiter sharing the single photonic data-plane channel.
// One node is granted at a time: a one-cycle start pulse is fired, the
// channel is held until that node's completion pulse (or a timeout), and
// a guard cycle separates consecutive owners.
module data_plane_arbiter #(
    parameter int NODES   = 4,
    parameter int TIMEOUT = 16,
    parameter int IDW     = $clog2(NODES)
) (
    input  logic                clk,
    input  logic                rst,
    data_plane_arbiter_if.master bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        WAIT  = 2'd2,
        GAP   = 2'd3
    } state_t;

    // Timer only needs to reach TIMEOUT-1.
    localparam int TW = $clog2(TIMEOUT);
    // One extra bit so (last + 1 + offset) can exceed NODES before wrap.
    localparam int SW = IDW + 1;

    state_t           state_reg;
    logic [TW-1:0]    timer_reg;
    logic [IDW-1:0]   last_reg;
    logic [IDW-1:0]   owner_reg;
    logic [NODES-1:0] flag_reg;
    logic             busy_reg;
    logic             terr_reg;
    logic [15:0]      count_reg;

    // Candidate node for each scan position: (last + 1 + gi) mod NODES.
    logic [IDW-1:0] cand_idx [NODES];

    generate
        for (genvar gi = 0; gi < NODES; gi++) begin : g_cand
            logic [SW-1:0] sum;
            assign sum = SW'(last_reg) + SW'(gi + 1);
            assign cand_idx[gi] = (sum >= SW'(NODES)) ? IDW'(sum - SW'(NODES))
                                                      : IDW'(sum);
        end
    endgenerate

    logic [IDW-1:0] pick_idx;
    logic           pick_valid;

    // Scan from the far end back so the nearest requester after last wins.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = last_reg;
        for (int k = NODES - 1; k >= 0; k--) begin
            if (bus.req[cand_idx[k]]) begin
                pick_valid = 1'b1;
                pick_idx   = cand_idx[k];
            end
        end
    end

    // Arbitration FSM; every output is a register updated here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            timer_reg <= '0;
            last_reg  <= IDW'(NODES - 1);
            owner_reg <= IDW'(NODES - 1);
            flag_reg  <= '0;
            busy_reg  <= 1'b0;
            terr_reg  <= 1'b0;
            count_reg <= '0;
        end else begin
            // Start pulse and timeout pulse are single-cycle by default.
            flag_reg <= '0;
            terr_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (pick_valid) begin
                        owner_reg <= pick_idx;
                        flag_reg  <= NODES'(1) << pick_idx;
                        count_reg <= count_reg + 16'd1;
                        busy_reg  <= 1'b1;
                        state_reg <= GRANT;
                    end
                end
                GRANT: begin
                    timer_reg <= '0;
                    state_reg <= WAIT;
                end
                WAIT: begin
                    // Completion has priority over a coincident timeout.
                    if (bus.complete[owner_reg]) begin
                        last_reg  <= owner_reg;
                        state_reg <= GAP;
                    end else if (timer_reg == TW'(TIMEOUT - 1)) begin
                        terr_reg  <= 1'b1;
                        last_reg  <= owner_reg;
                        state_reg <= GAP;
                    end else begin
                        timer_reg <= timer_reg + 1'b1;
                    end
                end
                GAP: begin
                    // Guard cycle lets the previous owner's trailer clear.
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.data_tx_flag = flag_reg;
    assign bus.grant_id     = owner_reg;
    assign bus.busy         = busy_reg;
    assign bus.timeout_err  = terr_reg;
    assign bus.grant_count  = count_reg;
endmodule

// File: tb/tb_data_plane_arbiter.sv
// Directed bench for data_plane_arbiter (NODES=4, TIMEOUT=16).
// Inputs change 1 time unit after a rising edge; outputs are sampled there.
// "Cycle N" is the interval after the N-th edge following stimulus start.
module tb_data_plane_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    data_plane_arbiter_if #(.NODES(4)) bus ();

    data_plane_arbiter #(.NODES(4), .TIMEOUT(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        bus.req = 4'b0000;
        bus.complete = 4'b0000;
        tick();
        tick();
        rst = 1'b0;
    endtask

    logic [3:0] exp_flag;
    int         bad;

    initial begin
        bus.req = 4'b0000;
        bus.complete = 4'b0000;

        // Reset state, then idle with no requests for 20 cycles.
        reset_dut();
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_flag", 32'(bus.data_tx_flag), 32'd0);
        chk("rst_gid", 32'(bus.grant_id), 32'd3);
        chk("rst_cnt", 32'(bus.grant_count), 32'd0);
        chk("rst_terr", 32'(bus.timeout_err), 32'd0);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.busy !== 1'b0 || bus.data_tx_flag !== 4'b0000) bad++;
        end
        chk("idle20_activity", 32'(bad), 32'd0);
        chk("idle20_cnt", 32'(bus.grant_count), 32'd0);
        chk("idle20_gid", 32'(bus.grant_id), 32'd3);

        // Single transfer from node 2; complete 7 cycles after the flag.
        bus.req = 4'b0100;                  // cycle 0
        tick();                             // cycle 1: GRANT
        chk("t2_flag", 32'(bus.data_tx_flag), 32'h4);
        chk("t2_gid", 32'(bus.grant_id), 32'd2);
        chk("t2_cnt", 32'(bus.grant_count), 32'd1);
        chk("t2_busy_grant", 32'(bus.busy), 32'd1);
        bus.req = 4'b0000;
        bad = 0;
        for (int c = 2; c <= 8; c++) begin
            tick();
            if (bus.busy !== 1'b1 || bus.data_tx_flag !== 4'b0000 || bus.timeout_err !== 1'b0) bad++;
        end
        chk("t2_wait", 32'(bad), 32'd0);
        bus.complete = 4'b0100;             // cycle 8
        tick();                             // cycle 9: GAP
        bus.complete = 4'b0000;
        chk("t2_gap_busy", 32'(bus.busy), 32'd1);
        chk("t2_gap_terr", 32'(bus.timeout_err), 32'd0);
        tick();                             // cycle 10: IDLE
        chk("t2_idle_busy", 32'(bus.busy), 32'd0);
        chk("t2_final_cnt", 32'(bus.grant_count), 32'd1);

        // All nodes requesting: grants 0,1,2,3,0, one every 10 cycles.
        reset_dut();
        bus.req = 4'b1111;                  // cycle 0
        for (int g = 0; g < 5; g++) begin
            tick();                         // flag cycle 1 + 10g
            exp_flag = 4'b0001 << (g % 4);
            chk($sformatf("rr%0d_flag", g), 32'(bus.data_tx_flag), 32'(exp_flag));
            chk($sformatf("rr%0d_gid", g), 32'(bus.grant_id), 32'(g % 4));
            if (g == 4) bus.req = 4'b0000;
            repeat (7) tick();              // flag + 7
            bus.complete = exp_flag;
            tick();                         // GAP
            bus.complete = 4'b0000;
            tick();                         // IDLE
            chk($sformatf("rr%0d_idle", g), 32'({bus.busy, bus.data_tx_flag}), 32'd0);
        end
        chk("rr_cnt", 32'(bus.grant_count), 32'd5);

        // Node 1 never completes: timeout after 16 WAIT cycles, then regrant.
        reset_dut();
        bus.req = 4'b0010;                  // cycle 0
        tick();                             // cycle 1: GRANT
        chk("to_flag", 32'(bus.data_tx_flag), 32'h2);
        bad = 0;
        for (int c = 2; c <= 17; c++) begin
            tick();
            if (bus.timeout_err !== 1'b0 || bus.busy !== 1'b1) bad++;
        end
        chk("to_early", 32'(bad), 32'd0);
        tick();                             // cycle 18: GAP
        chk("to_terr", 32'(bus.timeout_err), 32'd1);
        chk("to_gap_busy", 32'(bus.busy), 32'd1);
        tick();                             // cycle 19: IDLE
        chk("to_terr_drop", 32'(bus.timeout_err), 32'd0);
        chk("to_idle_busy", 32'(bus.busy), 32'd0);
        tick();                             // cycle 20: GRANT again
        chk("to_regrant", 32'(bus.data_tx_flag), 32'h2);
        chk("to_cnt", 32'(bus.grant_count), 32'd2);

        // Owner 0: non-owner complete ignored, completion at timer=15 wins.
        reset_dut();
        bus.req = 4'b0001;                  // cycle 0
        tick();                             // cycle 1: GRANT
        bus.req = 4'b0000;
        tick();
        tick();                             // cycle 3
        bus.complete = 4'b1000;
        tick();                             // cycle 4
        bus.complete = 4'b0000;
        chk("no_busy", 32'(bus.busy), 32'd1);
        chk("no_gid", 32'(bus.grant_id), 32'd0);
        repeat (13) tick();                 // cycle 17: timer = 15
        chk("no_still_busy", 32'(bus.busy), 32'd1);
        bus.complete = 4'b0001;
        tick();                             // cycle 18: GAP
        bus.complete = 4'b0000;
        chk("race_terr", 32'(bus.timeout_err), 32'd0);
        chk("race_gap_busy", 32'(bus.busy), 32'd1);
        tick();                             // cycle 19: IDLE
        chk("race_idle", 32'(bus.busy), 32'd0);

        // Reset in the 3rd WAIT cycle, then regrant after release.
        reset_dut();
        bus.req = 4'b0001;                  // cycle 0
        tick();                             // cycle 1: GRANT
        tick();
        tick();
        tick();                             // cycle 4: 3rd WAIT cycle
        rst = 1'b1;
        tick();                             // cycle 5
        chk("mr_busy", 32'(bus.busy), 32'd0);
        chk("mr_flag", 32'(bus.data_tx_flag), 32'd0);
        chk("mr_cnt", 32'(bus.grant_count), 32'd0);
        chk("mr_gid", 32'(bus.grant_id), 32'd3);
        chk("mr_terr", 32'(bus.timeout_err), 32'd0);
        rst = 1'b0;
        chk("mr_rel1", 32'(bus.data_tx_flag), 32'd0);
        tick();                             // 2nd cycle after release
        chk("mr_rel2_flag", 32'(bus.data_tx_flag), 32'h1);
        chk("mr_rel2_cnt", 32'(bus.grant_count), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
